// File: rtl/wallace_pkg.sv
// Shared types and helpers for the Wallace compressor and its carry-propagate
// back end. A package cannot take parameters, so the pair type here is sized
// at the default tree output width; modules that are re-parameterised declare
// a local pair type of the same shape.
package wallace_pkg;

  localparam int CSA_DW = 16;

  // Carry-save pair handed from the compression tree to the resolver.
  typedef struct packed {
    logic [CSA_DW-1:0] sum;
    logic [CSA_DW-1:0] carry;
  } csa_pair_t;

  // Number of segment stages (and cycles of latency) for a resolver.
  function automatic int stg_n(input int dw, input int seg_w);
    return dw / seg_w;
  endfunction

endpackage

// File: rtl/csa_seg_stage.sv
// One pipeline stage of the segmented resolver: adds slice K of the incoming
// sum/carry vectors plus the carry from the previous slice, and registers the
// partially resolved word, the vectors still to be resolved, the slice carry
// and the valid bit.
module csa_seg_stage #(
  parameter int DW    = 16,
  parameter int SEG_W = 4,
  parameter int K     = 0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_ld,
  input  logic          i_vld,
  input  logic [DW-1:0] i_res,
  input  logic [DW-1:0] i_sum,
  input  logic [DW-1:0] i_carry,
  input  logic          i_cin,
  output logic          o_vld,
  output logic [DW-1:0] o_res,
  output logic [DW-1:0] o_sum,
  output logic [DW-1:0] o_carry,
  output logic          o_cout
);

  localparam int LO = K * SEG_W;

  logic [SEG_W:0]  w_add;
  logic [DW-1:0]   w_res;

  logic            r_vld;
  logic [DW-1:0]   r_res;
  logic [DW-1:0]   r_sum;
  logic [DW-1:0]   r_carry;
  logic            r_cout;

  // Slice adder: resolve bits [LO +: SEG_W] and splice them into the word.
  always_comb begin
    // NOTE: every always_comb output is given a full default first so no
    // path through the block can leave it unassigned and infer a latch.
    w_res = i_res;
    w_add = {1'b0, i_sum[LO +: SEG_W]} + {1'b0, i_carry[LO +: SEG_W]}
          + {{SEG_W{1'b0}}, i_cin};
    w_res[LO +: SEG_W] = w_add[SEG_W-1:0];
  end

  // Stage register: loads whenever the slot is free or moving on, even for
  // bubbles; only the valid bit decides whether the contents mean anything.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // stage samples its neighbour's pre-edge value and the pipe shifts cleanly.
    if (!i_rst_n) begin
      // NOTE: the data registers are cleared as well as the valid bit, so the
      // result port reads zero after reset rather than stale arithmetic.
      r_vld   <= 1'b0;
      r_res   <= '0;
      r_sum   <= '0;
      r_carry <= '0;
      r_cout  <= 1'b0;
    end else if (i_ld) begin
      r_vld   <= i_vld;
      r_res   <= w_res;
      r_sum   <= i_sum;
      r_carry <= i_carry;
      r_cout  <= w_add[SEG_W];
    end
  end

  assign o_vld   = r_vld;
  assign o_res   = r_res;
  assign o_sum   = r_sum;
  assign o_carry = r_carry;
  assign o_cout  = r_cout;

endmodule

// File: rtl/csa_resolve_pipe.sv
// Pipelined carry-propagate adder that turns a carry-save pair into one binary
// result, SEG_W bits per stage. The stages hold the data; this level only
// wires them in a chain and computes the backward ready (load-enable) chain.
module csa_resolve_pipe
  import wallace_pkg::*;
#(
  parameter int DW    = 16,
  parameter int SEG_W = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_vld,
  output logic          o_rdy,
  input  logic [DW-1:0] i_sum,
  input  logic [DW-1:0] i_carry,
  output logic          o_vld,
  input  logic          i_rdy,
  output logic [DW-1:0] o_res,
  output logic          o_cout
);

  localparam int STG_N = stg_n(DW, SEG_W);

  typedef struct packed {
    logic [DW-1:0] sum;
    logic [DW-1:0] carry;
  } pair_t;

  if ((DW % SEG_W) != 0) begin : g_bad_cfg
    $error("csa_resolve_pipe: DW (%0d) must be a multiple of SEG_W (%0d)", DW, SEG_W);
  end

  // Index 0 is the block input; index k+1 is the output of stage k.
  pair_t           w_in;
  logic [STG_N:0]  w_vld;
  logic [DW-1:0]   w_res   [STG_N+1];
  logic [DW-1:0]   w_sum   [STG_N+1];
  logic [DW-1:0]   w_carry [STG_N+1];
  logic [STG_N:0]  w_cout;
  logic [STG_N:0]  w_ld;
  logic            w_unused_tail;

  assign w_in       = '{sum: i_sum, carry: i_carry};
  assign w_vld[0]   = i_vld;
  assign w_res[0]   = '0;
  assign w_sum[0]   = w_in.sum;
  assign w_carry[0] = w_in.carry;
  assign w_cout[0]  = 1'b0;

  // Ready chain: a stage loads if it is empty or the stage after it moves.
  always_comb begin
    w_ld        = '0;
    w_ld[STG_N] = i_rdy;
    for (int k = STG_N - 1; k >= 0; k--) begin
      w_ld[k] = !w_vld[k+1] || w_ld[k+1];
    end
  end

  for (genvar k = 0; k < STG_N; k++) begin : g_stg
    csa_seg_stage #(
      .DW    (DW),
      .SEG_W (SEG_W),
      .K     (k)
    ) u_stage (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_ld    (w_ld[k]),
      .i_vld   (w_vld[k]),
      .i_res   (w_res[k]),
      .i_sum   (w_sum[k]),
      .i_carry (w_carry[k]),
      .i_cin   (w_cout[k]),
      .o_vld   (w_vld[k+1]),
      .o_res   (w_res[k+1]),
      .o_sum   (w_sum[k+1]),
      .o_carry (w_carry[k+1]),
      .o_cout  (w_cout[k+1])
    );
  end

  // The last stage's operand copies have no consumer.
  assign w_unused_tail = ^{w_sum[STG_N], w_carry[STG_N]};

  assign o_rdy  = w_ld[0];
  assign o_vld  = w_vld[STG_N];
  assign o_res  = w_res[STG_N];
  assign o_cout = w_cout[STG_N];

endmodule

// File: tb/tb_csa_resolve_pipe.sv
// Self-checking bench for csa_resolve_pipe (DW=16, SEG_W=4). A queue of
// expected {cout, result} values, computed as plain 17-bit sums of each
// accepted pair, is compared against every emitted result in order.
module tb_csa_resolve_pipe;

  localparam int DW    = 16;
  localparam int SEG_W = 4;
  localparam int STG_N = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_vld;
  logic          o_rdy;
  logic [DW-1:0] i_sum;
  logic [DW-1:0] i_carry;
  logic          o_vld;
  logic          i_rdy;
  logic [DW-1:0] o_res;
  logic          o_cout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_emit   = 0;

  logic [DW:0] exp_q[$];

  always #5 i_clk = ~i_clk;

  csa_resolve_pipe #(.DW(DW), .SEG_W(SEG_W)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_vld   (i_vld),
    .o_rdy   (o_rdy),
    .i_sum   (i_sum),
    .i_carry (i_carry),
    .o_vld   (o_vld),
    .i_rdy   (i_rdy),
    .o_res   (o_res),
    .o_cout  (o_cout)
  );

  // One clock: sample both handshakes mid-cycle, score any emitted result,
  // record any accepted pair, then return 1 ns after the rising edge.
  task automatic step(output bit acc, output bit emit);
    logic [DW:0] e;
    @(negedge i_clk);
    acc  = i_vld && o_rdy;
    emit = o_vld && i_rdy;
    if (emit) begin
      n_emit++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_spurious: got %h, expected no result", {o_cout, o_res});
      end else begin
        e = exp_q.pop_front();
        if ({o_cout, o_res} !== e) begin
          failures++;
          $display("FAIL sb_data: got %h, expected %h", {o_cout, o_res}, e);
        end
      end
    end
    if (acc) exp_q.push_back({1'b0, i_sum} + {1'b0, i_carry});
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  // Drain with i_rdy=1 until the model queue is empty or the budget runs out.
  task automatic drain(input string name, input int budget);
    bit a, em;
    i_vld = 1'b0;
    i_rdy = 1'b1;
    for (int c = 0; c < budget && exp_q.size() != 0; c++) step(a, em);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d results outstanding, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    bit a, em;
    i_rst_n = 1'b0;
    i_vld   = 1'b0;
    i_rdy   = 1'b0;
    i_sum   = '0;
    i_carry = '0;
    step(a, em);
    step(a, em);
    i_rst_n = 1'b1;
    checks += 4;
    if (o_vld !== 1'b0) begin failures++; $display("FAIL rst_vld: got %b, expected 0", o_vld); end
    if (o_res !== '0)   begin failures++; $display("FAIL rst_res: got %h, expected 0000", o_res); end
    if (o_cout !== 1'b0) begin failures++; $display("FAIL rst_cout: got %b, expected 0", o_cout); end
    if (o_rdy !== 1'b1) begin failures++; $display("FAIL rst_rdy: got %b, expected 1", o_rdy); end
  endtask

  task automatic test_ripple();
    bit a, em;
    i_rdy   = 1'b1;
    i_vld   = 1'b1;
    i_sum   = 16'hFFFF;
    i_carry = 16'h0001;
    step(a, em);
    i_vld = 1'b0;
    checks++;
    if (a !== 1'b1) begin failures++; $display("FAIL ripple_accept: got %b, expected 1", a); end
    for (int i = 0; i < STG_N - 1; i++) begin
      checks++;
      if (o_vld !== 1'b0) begin
        failures++;
        $display("FAIL ripple_early: o_vld=%b after %0d cycles, expected 0", o_vld, i + 1);
      end
      step(a, em);
    end
    checks += 3;
    if (o_vld !== 1'b1) begin failures++; $display("FAIL ripple_latency: o_vld=%b, expected 1", o_vld); end
    if (o_res !== 16'h0000) begin failures++; $display("FAIL ripple_res: got %h, expected 0000", o_res); end
    if (o_cout !== 1'b1) begin failures++; $display("FAIL ripple_cout: got %b, expected 1", o_cout); end
    drain("ripple", 4);
  endtask

  task automatic test_no_carry();
    bit a, em;
    int first, last, base;
    i_rdy   = 1'b1;
    i_vld   = 1'b1;
    i_sum   = 16'h1234;
    i_carry = 16'h4321;
    step(a, em);
    i_vld = 1'b0;
    for (int c = 0; c < 10 && !o_vld; c++) step(a, em);
    checks += 2;
    if (o_res !== 16'h5555) begin failures++; $display("FAIL nocarry_res: got %h, expected 5555", o_res); end
    if (o_cout !== 1'b0) begin failures++; $display("FAIL nocarry_cout: got %b, expected 0", o_cout); end
    drain("nocarry", 4);

    // Back-to-back stream of 8 pairs.
    first = -1;
    last  = -1;
    base  = n_emit;
    for (int n = 0; n < 8 + 12; n++) begin
      i_vld   = (n < 8);
      i_sum   = 16'(16'h1111 * n);
      i_carry = 16'h0001;
      if (n < 8) begin
        checks++;
        if (o_rdy !== 1'b1) begin failures++; $display("FAIL b2b_rdy: item %0d o_rdy=%b, expected 1", n, o_rdy); end
      end
      step(a, em);
      if (em) begin
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    checks += 2;
    if (n_emit - base != 8) begin failures++; $display("FAIL b2b_count: got %0d results, expected 8", n_emit - base); end
    if (last - first != 7) begin failures++; $display("FAIL b2b_gap: span %0d cycles, expected 7", last - first); end
    drain("b2b", 4);
  endtask

  task automatic test_backpressure();
    bit a, em;
    int idx, base;
    logic [DW-1:0] s_t [6];
    logic [DW-1:0] c_t [6];
    logic [DW-1:0] hold;
    for (int i = 0; i < 6; i++) begin
      s_t[i] = DW'($urandom);
      c_t[i] = DW'($urandom);
    end
    idx  = 0;
    base = n_emit;
    i_rdy = 1'b1;
    for (int c = 0; c < 40 && !o_vld; c++) begin
      i_vld   = (idx < 6);
      i_sum   = s_t[idx % 6];
      i_carry = c_t[idx % 6];
      step(a, em);
      if (a) idx++;
    end
    checks++;
    if (o_vld !== 1'b1) begin failures++; $display("FAIL bp_timeout: o_vld=%b, expected 1", o_vld); end
    i_rdy   = 1'b0;
    i_vld   = (idx < 6);
    i_sum   = s_t[idx % 6];
    i_carry = c_t[idx % 6];
    step(a, em);
    if (a) idx++;
    checks += 2;
    if (o_rdy !== 1'b0) begin failures++; $display("FAIL bp_full_rdy: got %b, expected 0", o_rdy); end
    if (idx != 4) begin failures++; $display("FAIL bp_held: got %0d items accepted, expected 4", idx); end
    hold = o_res;
    for (int c = 0; c < 5; c++) begin
      step(a, em);
      if (a) idx++;
      checks++;
      if (o_res !== hold || o_vld !== 1'b1) begin
        failures++;
        $display("FAIL bp_stable: o_res=%h o_vld=%b, expected %h and 1", o_res, o_vld, hold);
      end
    end
    i_rdy = 1'b1;
    for (int c = 0; c < 30 && idx < 6; c++) begin
      i_vld   = 1'b1;
      i_sum   = s_t[idx];
      i_carry = c_t[idx];
      step(a, em);
      if (a) idx++;
    end
    drain("bp", 10);
    checks++;
    if (n_emit - base != 6) begin failures++; $display("FAIL bp_count: got %0d results, expected 6", n_emit - base); end
  endtask

  task automatic test_bubbles();
    bit a, em;
    int idx, base;
    idx   = 0;
    base  = n_emit;
    i_rdy = 1'b0;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      i_vld   = (c % 2 == 0);
      i_sum   = DW'($urandom);
      i_carry = DW'($urandom);
      checks++;
      if (o_rdy !== 1'b1) begin failures++; $display("FAIL bub_rdy: %0d held, o_rdy=%b, expected 1", idx, o_rdy); end
      step(a, em);
      if (a) idx++;
    end
    i_vld = 1'b0;
    step(a, em);
    checks += 2;
    if (o_rdy !== 1'b0) begin failures++; $display("FAIL bub_full: o_rdy=%b, expected 0", o_rdy); end
    if (o_vld !== 1'b1) begin failures++; $display("FAIL bub_vld: o_vld=%b, expected 1", o_vld); end
    drain("bub", 10);
    checks++;
    if (n_emit - base != 4) begin failures++; $display("FAIL bub_count: got %0d results, expected 4", n_emit - base); end
  endtask

  task automatic test_reset_midflight();
    bit a, em;
    i_rdy = 1'b0;
    for (int n = 0; n < 3; n++) begin
      i_vld   = 1'b1;
      i_sum   = DW'($urandom);
      i_carry = DW'($urandom);
      step(a, em);
    end
    i_vld   = 1'b0;
    i_rst_n = 1'b0;
    step(a, em);
    i_rst_n = 1'b1;
    exp_q.delete();
    checks += 3;
    if (o_vld !== 1'b0) begin failures++; $display("FAIL mrst_vld: got %b, expected 0", o_vld); end
    if (o_res !== '0)   begin failures++; $display("FAIL mrst_res: got %h, expected 0000", o_res); end
    if (o_rdy !== 1'b1) begin failures++; $display("FAIL mrst_rdy: got %b, expected 1", o_rdy); end
    i_rdy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step(a, em);
      checks++;
      if (o_vld !== 1'b0) begin failures++; $display("FAIL mrst_stale: o_vld=%b at cycle %0d, expected 0", o_vld, c); end
    end
  endtask

  task automatic test_random();
    bit a, em;
    int n_acc, base;
    n_acc = 0;
    base  = n_emit;
    a     = 1'b1;
    i_vld = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      // A pending pair is held unchanged until it is accepted.
      if (!i_vld || a) begin
        i_vld = ($urandom_range(0, 9) < 7);
        case ($urandom_range(0, 7))
          0:       begin i_sum = '1; i_carry = '1; end
          1:       begin i_sum = '1; i_carry = 16'h0001; end
          default: begin i_sum = DW'($urandom); i_carry = DW'($urandom); end
        endcase
      end
      i_rdy = ($urandom_range(0, 9) < 6);
      step(a, em);
      if (a) n_acc++;
    end
    drain("rand", 20);
    checks++;
    if (n_emit - base != n_acc) begin
      failures++;
      $display("FAIL rand_count: got %0d results, expected %0d", n_emit - base, n_acc);
    end
  endtask

  initial begin
    test_reset();
    test_ripple();
    test_no_carry();
    test_backpressure();
    test_bubbles();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
